// File: rtl/car_gate_ctrl.sv
// ---------------------------------------------------------------------------
// car_gate_ctrl
//   Lane sensor front-end for the garage. Two beams cross the lane: sens_a on
//   the street side, sens_b on the garage side. Both are synchronized and
//   debounced. A direction FSM then follows each car through the beams. It
//   emits one-cycle entry/exit pulses for the occupancy counter, drives the
//   barrier and refuses entry while the counter reports full.
//
// Ports
//   clk        system clock, all state on the rising edge
//   reset      asynchronous, active-high, clears all state
//   sens_a     raw street-side beam (1 = blocked), asynchronous to clk
//   sens_b     raw garage-side beam (1 = blocked), asynchronous to clk
//   full       occupancy counter at capacity (looked at only in IDLE)
//   empty      occupancy counter at zero (looked at only in IDLE)
//   car_in     one-cycle pulse, completed entry
//   car_out    one-cycle pulse, completed exit
//   denied     one-cycle pulse, entry refused because full
//   gate_open  barrier drive, 1 = raised (any IN_*/OUT_* state)
//   err        high while in FAULT
//   state      current FSM state encoding
// ---------------------------------------------------------------------------
module car_gate_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int TIMEOUT    = 1000,
    parameter int TW         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sens_a,
    input  logic       sens_b,
    input  logic       full,
    input  logic       empty,
    output logic       car_in,
    output logic       car_out,
    output logic       denied,
    output logic       gate_open,
    output logic       err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IN_A   = 3'd1,
        IN_AB  = 3'd2,
        IN_B   = 3'd3,
        OUT_B  = 3'd4,
        OUT_AB = 3'd5,
        OUT_A  = 3'd6,
        FAULT  = 3'd7
    } state_t;

    localparam logic [TW-1:0] DEB_LAST = TW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    // Stage p0/p1: two-flop synchronizers for the raw beams
    logic sa_p0, sa_p1;
    logic sb_p0, sb_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sa_p0 <= 1'b0;
            sa_p1 <= 1'b0;
            sb_p0 <= 1'b0;
            sb_p1 <= 1'b0;
        end else begin
            sa_p0 <= sens_a;
            sa_p1 <= sa_p0;
            sb_p0 <= sens_b;
            sb_p1 <= sb_p0;
        end
    end

    // Stage p2: debounce. A counter runs while the synchronized value
    // disagrees with the debounced one; any agreement clears it.
    logic          deb_a, deb_b;
    logic [TW-1:0] cnt_a, cnt_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_a <= 1'b0;
            deb_b <= 1'b0;
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (sa_p1 == deb_a) begin
                cnt_a <= '0;
            end else if (cnt_a == DEB_LAST) begin
                deb_a <= sa_p1;
                cnt_a <= '0;
            end else begin
                cnt_a <= cnt_a + 1'b1;
            end

            if (sb_p1 == deb_b) begin
                cnt_b <= '0;
            end else if (cnt_b == DEB_LAST) begin
                deb_b <= sb_p1;
                cnt_b <= '0;
            end else begin
                cnt_b <= cnt_b + 1'b1;
            end
        end
    end

    // Stage p3: direction FSM on debounced beams
    state_t        cur, nxt;
    logic [TW-1:0] tmo;
    logic          deny_hold, deny_hold_nxt;
    logic          car_in_nxt, car_out_nxt, denied_nxt;
    logic [1:0]    ab;
    logic          in_passage;

    assign ab         = {deb_a, deb_b};
    assign in_passage = (cur != IDLE) && (cur != FAULT);

    always_comb begin
        nxt         = cur;
        car_in_nxt  = 1'b0;
        car_out_nxt = 1'b0;
        denied_nxt  = 1'b0;
        // A refused car keeps the hold until it clears the street beam, so
        // one car sitting in front of a full garage yields only one pulse.
        deny_hold_nxt = deny_hold & deb_a;

        unique case (cur)
            IDLE: begin
                case (ab)
                    2'b10: begin
                        if (!deny_hold) begin
                            if (full) begin
                                denied_nxt    = 1'b1;
                                deny_hold_nxt = 1'b1;
                            end else begin
                                nxt = IN_A;
                            end
                        end
                    end
                    2'b01:   nxt = empty ? FAULT : OUT_B;
                    2'b11:   nxt = FAULT;
                    default: nxt = IDLE;
                endcase
            end
            IN_A: begin
                case (ab)
                    2'b11:   nxt = IN_AB;
                    2'b00:   nxt = IDLE;     // backed out
                    2'b10:   nxt = IN_A;
                    default: nxt = FAULT;
                endcase
            end
            IN_AB: begin
                case (ab)
                    2'b01:   nxt = IN_B;
                    2'b10:   nxt = IN_A;
                    2'b11:   nxt = IN_AB;
                    default: nxt = FAULT;
                endcase
            end
            IN_B: begin
                case (ab)
                    2'b00: begin
                        nxt        = IDLE;
                        car_in_nxt = 1'b1;
                    end
                    2'b11:   nxt = IN_AB;
                    2'b01:   nxt = IN_B;
                    default: nxt = FAULT;
                endcase
            end
            OUT_B: begin
                case (ab)
                    2'b11:   nxt = OUT_AB;
                    2'b00:   nxt = IDLE;     // backed out
                    2'b01:   nxt = OUT_B;
                    default: nxt = FAULT;
                endcase
            end
            OUT_AB: begin
                case (ab)
                    2'b10:   nxt = OUT_A;
                    2'b01:   nxt = OUT_B;
                    2'b11:   nxt = OUT_AB;
                    default: nxt = FAULT;
                endcase
            end
            OUT_A: begin
                case (ab)
                    2'b00: begin
                        nxt         = IDLE;
                        car_out_nxt = 1'b1;
                    end
                    2'b11:   nxt = OUT_AB;
                    2'b10:   nxt = OUT_A;
                    default: nxt = FAULT;
                endcase
            end
            FAULT: begin
                if (ab == 2'b00) begin
                    nxt = IDLE;
                end
            end
        endcase

        // tmo counts cycles already spent in the passage; the cycle that
        // would be number TIMEOUT is replaced by FAULT, beating any event.
        if (in_passage && (tmo == TMO_LAST)) begin
            nxt         = FAULT;
            car_in_nxt  = 1'b0;
            car_out_nxt = 1'b0;
        end
    end

    // Stage p4: registered state and outputs, all aligned to the new state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur       <= IDLE;
            tmo       <= '0;
            deny_hold <= 1'b0;
            car_in    <= 1'b0;
            car_out   <= 1'b0;
            denied    <= 1'b0;
            gate_open <= 1'b0;
            err       <= 1'b0;
        end else begin
            cur       <= nxt;
            tmo       <= in_passage ? tmo + 1'b1 : '0;
            deny_hold <= deny_hold_nxt;
            car_in    <= car_in_nxt;
            car_out   <= car_out_nxt;
            denied    <= denied_nxt;
            gate_open <= (nxt != IDLE) && (nxt != FAULT);
            err       <= (nxt == FAULT);
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_car_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_car_gate_ctrl
//   Scoreboard bench for car_gate_ctrl. Each stimulus cycle runs a reference
//   model of the lane (sample delay line, stable-window debounce, passage
//   position along the beam pattern) and queues the expected registered
//   outputs; a monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_car_gate_ctrl;

    localparam int DEB = 2;
    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       reset;
    logic       sens_a, sens_b, full, empty;
    logic       car_in, car_out, denied, gate_open, err;
    logic [2:0] state;

    car_gate_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT(TMO), .TW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .sens_a    (sens_a),
        .sens_b    (sens_b),
        .full      (full),
        .empty     (empty),
        .car_in    (car_in),
        .car_out   (car_out),
        .denied    (denied),
        .gate_open (gate_open),
        .err       (err),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       ci;
        logic       co;
        logic       dn;
        logic       go;
        logic       er;
    } exp_t;

    exp_t exp_q[$];
    exp_t mx;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cnt_in  = 0;
    int   cnt_out = 0;
    int   cnt_den = 0;

    // Reference model: mode 0 idle, 1 entering, 2 leaving, 3 fault;
    // pos = how far along the three-step beam pattern the car is.
    logic m_ra_q[$], m_rb_q[$];
    logic m_wa[$], m_wb[$];
    logic m_deb_a, m_deb_b, m_hold;
    int   m_mode, m_pos, m_edge, m_enter;

    task automatic model_reset();
        m_ra_q = '{1'b0, 1'b0};
        m_rb_q = '{1'b0, 1'b0};
        m_wa.delete();
        m_wb.delete();
        for (int i = 0; i < DEB; i++) begin
            m_wa.push_back(1'b0);
            m_wb.push_back(1'b0);
        end
        m_deb_a = 1'b0;
        m_deb_b = 1'b0;
        m_hold  = 1'b0;
        m_mode  = 0;
        m_pos   = 0;
        m_edge  = 0;
        m_enter = 0;
    endtask

    function automatic logic all_differ(input logic q[$], input logic v);
        foreach (q[i]) if (q[i] == v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input logic ra, input logic rb, input logic f, input logic e);
        logic [1:0] ab;
        logic [1:0] pat [3];
        logic       ci, co, dn, sa, sb;
        int         n_mode, n_pos, code;
        exp_t       x;
        ab     = {m_deb_a, m_deb_b};
        ci     = 1'b0;
        co     = 1'b0;
        dn     = 1'b0;
        n_mode = m_mode;
        n_pos  = m_pos;
        m_edge++;
        if (m_mode == 2) pat = '{2'b01, 2'b11, 2'b10};
        else             pat = '{2'b10, 2'b11, 2'b01};
        case (m_mode)
            0: begin
                if (ab == 2'b10 && !m_hold) begin
                    if (f) dn = 1'b1;
                    else begin n_mode = 1; n_pos = 0; m_enter = m_edge; end
                end else if (ab == 2'b01) begin
                    if (e) n_mode = 3;
                    else begin n_mode = 2; n_pos = 0; m_enter = m_edge; end
                end else if (ab == 2'b11) begin
                    n_mode = 3;
                end
            end
            3: if (ab == 2'b00) n_mode = 0;
            default: begin
                if (m_edge - m_enter >= TMO)                  n_mode = 3;
                else if (ab == pat[m_pos])                    n_pos = m_pos;
                else if (m_pos < 2 && ab == pat[m_pos + 1])   n_pos = m_pos + 1;
                else if (m_pos > 0 && ab == pat[m_pos - 1])   n_pos = m_pos - 1;
                else if (ab == 2'b00 && m_pos == 0)           n_mode = 0;
                else if (ab == 2'b00 && m_pos == 2) begin
                    n_mode = 0;
                    if (m_mode == 1) ci = 1'b1;
                    else             co = 1'b1;
                end else                                      n_mode = 3;
            end
        endcase
        m_hold = dn ? 1'b1 : (m_hold & m_deb_a);
        m_mode = n_mode;
        m_pos  = n_pos;

        // Sensor path: two-sample delay, then flip after DEB disagreeing samples
        sa = m_ra_q.pop_front();
        m_ra_q.push_back(ra);
        sb = m_rb_q.pop_front();
        m_rb_q.push_back(rb);
        void'(m_wa.pop_front());
        m_wa.push_back(sa);
        void'(m_wb.pop_front());
        m_wb.push_back(sb);
        if (all_differ(m_wa, m_deb_a)) m_deb_a = ~m_deb_a;
        if (all_differ(m_wb, m_deb_b)) m_deb_b = ~m_deb_b;

        case (m_mode)
            0:       code = 0;
            1:       code = 1 + m_pos;
            2:       code = 4 + m_pos;
            default: code = 7;
        endcase
        x.st = 3'(code);
        x.ci = ci;
        x.co = co;
        x.dn = dn;
        x.go = (m_mode == 1 || m_mode == 2);
        x.er = (m_mode == 3);
        exp_q.push_back(x);
    endtask

    // Monitor: one registered output vector per clock edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mx = exp_q.pop_front();
            n_tests++;
            if ({state, car_in, car_out, denied, gate_open, err} !== mx) begin
                n_fail++;
                if (n_fail < 40)
                    $display("FAIL cycle_out t=%0t got st=%0d ci=%b co=%b dn=%b go=%b er=%b want st=%0d ci=%b co=%b dn=%b go=%b er=%b",
                             $time, state, car_in, car_out, denied, gate_open, err,
                             mx.st, mx.ci, mx.co, mx.dn, mx.go, mx.er);
            end
            if (car_in)  cnt_in++;
            if (car_out) cnt_out++;
            if (denied)  cnt_den++;
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic step(input logic a, input logic b);
        sens_a = a;
        sens_b = b;
        @(posedge clk);
        #1;
        model_edge(a, b, full, empty);
    endtask

    task automatic hold(input logic a, input logic b, input int n);
        for (int i = 0; i < n; i++) step(a, b);
    endtask

    function automatic int rl();
        return int'($urandom_range(10, 3));
    endfunction

    int s_in, s_out, s_den;

    initial begin
        reset  = 1'b1;
        sens_a = 1'b0;
        sens_b = 1'b0;
        full   = 1'b0;
        empty  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({state, car_in, car_out, denied, gate_open, err}), 0);
        reset = 1'b0;

        // Entry
        hold(0, 0, 10);
        s_in = cnt_in; s_out = cnt_out;
        hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10); hold(0, 0, 10);
        chk("entry_car_in_pulses", cnt_in - s_in, 1);
        chk("entry_car_out_pulses", cnt_out - s_out, 0);

        // Exit, then an entry attempt that backs out
        s_in = cnt_in; s_out = cnt_out;
        hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10);
        chk("exit_car_out_pulses", cnt_out - s_out, 1);
        hold(1, 0, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 10);
        chk("backout_car_in_pulses", cnt_in - s_in, 0);
        chk("backout_state", int'(state), 0);

        // Full: one refusal per car
        full = 1'b1;
        s_den = cnt_den;
        hold(1, 0, 20);
        chk("deny_first", cnt_den - s_den, 1);
        chk("deny_gate_closed", int'(gate_open), 0);
        hold(0, 0, 10); hold(1, 0, 20);
        chk("deny_second", cnt_den - s_den, 2);
        hold(0, 0, 10);
        full = 1'b0;

        // Exit while empty is a fault
        empty = 1'b1;
        s_out = cnt_out;
        hold(0, 1, 15);
        chk("empty_fault_state", int'(state), 7);
        chk("empty_fault_err", int'(err), 1);
        hold(0, 0, 10);
        chk("fault_release_state", int'(state), 0);
        chk("fault_release_car_out", cnt_out - s_out, 0);
        empty = 1'b0;

        // Glitch shorter than the debounce window, then a stalled car
        step(1, 0);
        hold(0, 0, 10);
        chk("glitch_state", int'(state), 0);
        hold(1, 0, 60);
        chk("timeout_state", int'(state), 7);
        hold(0, 0, 10);

        // Asynchronous reset in the middle of a passage
        s_in = cnt_in;
        hold(1, 0, 10); hold(1, 1, 8);
        chk("pre_reset_state", int'(state), 2);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", int'({state, car_in, car_out, denied, gate_open, err}), 0);
        sens_a = 1'b0;
        sens_b = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        hold(0, 0, 12);
        chk("post_reset_car_in", cnt_in - s_in, 0);

        // Randomized traffic
        for (int s = 0; s < 200; s++) begin
            full  = ($urandom_range(3, 0) == 0);
            empty = ($urandom_range(3, 0) == 0);
            case ($urandom_range(3, 0))
                0: begin hold(1, 0, rl()); hold(1, 1, rl()); hold(0, 1, rl()); hold(0, 0, rl()); end
                1: begin hold(0, 1, rl()); hold(1, 1, rl()); hold(1, 0, rl()); hold(0, 0, rl()); end
                2: begin
                    hold(1, 0, rl()); hold(1, 1, rl()); hold(1, 0, rl());
                    hold(1, 1, rl()); hold(0, 1, rl()); hold(0, 0, rl());
                end
                default: hold(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                              int'($urandom_range(8, 1)));
            endcase
        end
        hold(0, 0, 10);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
